// File: rtl/adam_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package adam_pipe_pkg;

    // Register addresses are stored zero-extended to this width, so slot_t stays fixed
    // while the controller's AW parameter may be anything up to AW_MAX.
    localparam int unsigned AW_MAX = 8;

    // Forward select value meaning "take the operand from the register file".
    localparam int unsigned FWD_RF = 0;

    // Slot indices of the named stages.
    localparam int unsigned SLOT_EX  = 0;
    localparam int unsigned SLOT_MEM = 1;
    localparam int unsigned SLOT_WB  = 2;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              ld;
        logic              mop;
        logic [AW_MAX-1:0] rd;
        logic [AW_MAX-1:0] rs1;
        logic [AW_MAX-1:0] rs2;
    } slot_t;

endpackage

// File: rtl/pipe_hazard_ctrl_slot_match.sv
// Compares one source register against the writer fields of one tracked slot.
// o_lo: hit on rd; o_hi: hit on the second mop result rd+1 (mod 2**AW).
module slot_match
    import adam_pipe_pkg::*;
#(
    parameter int unsigned AW = 6
) (
    input  logic [AW_MAX-1:0] i_rs,
    input  logic              i_valid,
    input  logic              i_wr,
    input  logic              i_mop,
    input  logic [AW_MAX-1:0] i_rd,
    output logic              o_lo,
    output logic              o_hi
);

    localparam logic [AW_MAX-1:0] RD_MASK = AW_MAX'((1 << AW) - 1);

    logic [AW_MAX-1:0] w_rd_inc;
    logic              w_live;

    // A wrapped rd+1 becomes 0, which the rs!=0 term already excludes.
    always_comb begin
        w_rd_inc = (i_rd + AW_MAX'(1)) & RD_MASK;
        w_live   = (i_rs != '0) && i_valid && i_wr;
        o_lo     = w_live && (i_rs == i_rd);
        o_hi     = w_live && i_mop && (i_rs == w_rd_inc);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: tracks in-flight writers from EX onward, raises the ID stall,
// selects EX operand forwarding sources and counts stall/flush cycles.
module pipe_hazard_ctrl
    import adam_pipe_pkg::*;
#(
    parameter int unsigned AW       = 6,
    parameter int unsigned NSLOT    = 3,
    parameter int unsigned LD_READY = 1,
    parameter int unsigned MOP_SER  = 1,
    parameter int unsigned CW       = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_iss_valid,
    input  logic                     i_iss_wr,
    input  logic                     i_iss_ld,
    input  logic                     i_iss_mop,
    input  logic [AW-1:0]            i_iss_rd,
    input  logic [AW-1:0]            i_iss_rs1,
    input  logic [AW-1:0]            i_iss_rs2,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic [$clog2(NSLOT)-1:0] o_fwd_a_sel,
    output logic                     o_fwd_a_hi,
    output logic [$clog2(NSLOT)-1:0] o_fwd_b_sel,
    output logic                     o_fwd_b_hi,
    output logic [CW-1:0]            o_stall_cnt,
    output logic [CW-1:0]            o_flush_cnt
);

    localparam int unsigned SW = $clog2(NSLOT);

    slot_t            r_slot [NSLOT];
    slot_t            w_id_entry;
    logic [CW-1:0]    r_stall_cnt;
    logic [CW-1:0]    r_flush_cnt;

    logic [NSLOT-1:0] w_id1_lo, w_id1_hi, w_id2_lo, w_id2_hi;
    logic [NSLOT-1:1] w_ex1_lo, w_ex1_hi, w_ex2_lo, w_ex2_hi;
    logic             w_load_use;
    logic             w_mop_busy;

    // Pack the ID instruction into slot form with zero-extended register addresses.
    always_comb begin
        w_id_entry       = '0;
        w_id_entry.valid = i_iss_valid;
        w_id_entry.wr    = i_iss_wr;
        w_id_entry.ld    = i_iss_ld;
        w_id_entry.mop   = i_iss_mop;
        w_id_entry.rd    = AW_MAX'(i_iss_rd);
        w_id_entry.rs1   = AW_MAX'(i_iss_rs1);
        w_id_entry.rs2   = AW_MAX'(i_iss_rs2);
    end

    // ID sources against every tracked slot.
    for (genvar k = 0; k < NSLOT; k++) begin : g_id
        slot_match #(.AW(AW)) u_rs1 (
            .i_rs    (w_id_entry.rs1),
            .i_valid (r_slot[k].valid),
            .i_wr    (r_slot[k].wr),
            .i_mop   (r_slot[k].mop),
            .i_rd    (r_slot[k].rd),
            .o_lo    (w_id1_lo[k]),
            .o_hi    (w_id1_hi[k])
        );
        slot_match #(.AW(AW)) u_rs2 (
            .i_rs    (w_id_entry.rs2),
            .i_valid (r_slot[k].valid),
            .i_wr    (r_slot[k].wr),
            .i_mop   (r_slot[k].mop),
            .i_rd    (r_slot[k].rd),
            .o_lo    (w_id2_lo[k]),
            .o_hi    (w_id2_hi[k])
        );
    end

    // EX sources against the older slots; slot0 is the consumer itself.
    for (genvar k = 1; k < NSLOT; k++) begin : g_ex
        slot_match #(.AW(AW)) u_rs1 (
            .i_rs    (r_slot[SLOT_EX].rs1),
            .i_valid (r_slot[k].valid),
            .i_wr    (r_slot[k].wr),
            .i_mop   (r_slot[k].mop),
            .i_rd    (r_slot[k].rd),
            .o_lo    (w_ex1_lo[k]),
            .o_hi    (w_ex1_hi[k])
        );
        slot_match #(.AW(AW)) u_rs2 (
            .i_rs    (r_slot[SLOT_EX].rs2),
            .i_valid (r_slot[k].valid),
            .i_wr    (r_slot[k].wr),
            .i_mop   (r_slot[k].mop),
            .i_rd    (r_slot[k].rd),
            .o_lo    (w_ex2_lo[k]),
            .o_hi    (w_ex2_hi[k])
        );
    end

    // Stall causes: load data not yet forwardable, or a mop still occupying early slots.
    always_comb begin
        w_load_use = 1'b0;
        w_mop_busy = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            if (k < LD_READY && r_slot[k].ld &&
                (w_id1_lo[k] || w_id1_hi[k] || w_id2_lo[k] || w_id2_hi[k])) begin
                w_load_use = 1'b1;
            end
            if (k < NSLOT - 1 && r_slot[k].valid && r_slot[k].mop) begin
                w_mop_busy = 1'b1;
            end
        end
        o_stall = i_iss_valid && !i_flush &&
                  (w_load_use || ((MOP_SER != 0) && i_iss_mop && w_mop_busy));
    end

    // Forward priority: scan oldest to youngest so the smallest matching slot wins.
    always_comb begin
        o_fwd_a_sel = SW'(FWD_RF);
        o_fwd_a_hi  = 1'b0;
        o_fwd_b_sel = SW'(FWD_RF);
        o_fwd_b_hi  = 1'b0;
        for (int k = NSLOT - 1; k >= 1; k--) begin
            if (r_slot[SLOT_EX].valid && (w_ex1_lo[k] || w_ex1_hi[k])) begin
                if (r_slot[k].ld && k < LD_READY) begin
                    o_fwd_a_sel = SW'(FWD_RF);
                    o_fwd_a_hi  = 1'b0;
                end else begin
                    o_fwd_a_sel = SW'(k);
                    o_fwd_a_hi  = w_ex1_hi[k];
                end
            end
            if (r_slot[SLOT_EX].valid && (w_ex2_lo[k] || w_ex2_hi[k])) begin
                if (r_slot[k].ld && k < LD_READY) begin
                    o_fwd_b_sel = SW'(FWD_RF);
                    o_fwd_b_hi  = 1'b0;
                end else begin
                    o_fwd_b_sel = SW'(k);
                    o_fwd_b_hi  = w_ex2_hi[k];
                end
            end
        end
    end

    // Slot pipeline: ID enters slot0 unless stalled or killed; everything else shifts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NSLOT; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            r_slot[SLOT_EX] <= (i_iss_valid && !o_stall && !i_flush) ? w_id_entry : '0;
            for (int k = 1; k < NSLOT; k++) begin
                r_slot[k] <= r_slot[k-1];
            end
        end
    end

    // Saturating performance counters; o_stall is already masked by flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
            if (i_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CW'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule
